avalon_st_capture: RTL and testbench
====================================

AVALON_ST_CAPTURE -- requirements
Module: avalon_st_capture

Interface
REQ-001 Parameter DATA_W, default 64, monitored data width in bits (8..512).
REQ-002 Parameter EMPTY_W, default 3, monitored empty width in bits.
REQ-003 Parameter DEPTH, default 16, capture buffer entries; power of 2, at least 2.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 Parameter TS_W, default 32, timestamp width; used only when the timestamp is compiled in.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-007 Monitored bus (observe only, no backpressure):
- mon_valid  in  1  beat valid.
- mon_startofpacket  in  1  first beat of packet.
- mon_endofpacket  in  1  last beat of packet.
- mon_data  in  DATA_W  beat data.
- mon_empty  in  EMPTY_W  empty bytes on the EOP beat.
REQ-008 Readout and status ports:
- rd_valid  out  1  capture record available.
- rd_ready  in  1  consumer accepts the record.
- rd_data  out  REC_W  record {[ts], sop, eop, empty, data}, data in the LSBs.
- pkt_count  out  CNT_W  completed packets captured.
- drop_count  out  CNT_W  packets truncated or dropped.
- err_proto  out  1  sticky flag: SOP/EOP protocol violation seen.
- overflow  out  1  sticky flag: buffer-full drop occurred.
- clear  in  1  synchronous clear of counters and sticky flags.

Function
REQ-009 A beat is a cycle with mon_valid=1; cycles with mon_valid=0 are ignored regardless of other inputs.
REQ-010 The FSM has three states, IDLE, IN_PKT and DROP, and resets to IDLE.
REQ-011 In IDLE, a beat with SOP=1 is written to the buffer; the next state is IN_PKT, or IDLE if EOP=1 on the same beat.
REQ-012 In IDLE, a beat with SOP=0 is discarded and sets err_proto; the state stays IDLE.
REQ-013 In IN_PKT, a beat is written to the buffer, and EOP=1 returns the state to IDLE and increments pkt_count.
REQ-014 In IN_PKT, a beat with SOP=1 sets err_proto, increments drop_count (previous packet truncated), is written, and starts a new packet.
REQ-015 Buffer full handling:
- If a beat must be written while the buffer is full and no pop occurs that cycle, the beat is discarded.
- overflow is set and drop_count increments.
- The state becomes DROP, or IDLE if that beat has EOP=1.
REQ-016 In DROP, all beats are discarded until the EOP beat, which returns the state to IDLE. A beat with SOP=1 in DROP is treated as in IDLE, and err_proto is set.
REQ-017 Write and read in the same cycle while full is allowed: the pop frees the slot and the write succeeds.
REQ-018 Buffer behaviour: synchronous FIFO, first-word fall-through, write-to-rd_valid latency of 1 cycle. A record is popped when rd_valid and rd_ready are both 1.
REQ-019 rd_data is stable while rd_valid=1 and rd_ready=0.
REQ-020 pkt_count and drop_count wrap modulo 2^CNT_W.
REQ-021 clear=1 zeroes the counters and sticky flags next cycle and does not affect the FSM or buffer; clear has priority over a simultaneous increment.

Reset
REQ-022 On reset_n=0, the following asynchronously clear to zero: FSM (IDLE), buffer pointers, occupancy, rd_valid, pkt_count, drop_count, err_proto, overflow and the timestamp counter. Buffer storage is not cleared.
REQ-023 Reset asserted mid-packet abandons the packet silently, with no counter or flag update; after release the monitor waits for SOP.

Configuration
REQ-024 Macro CAPTURE_TIMESTAMP_EN controls the timestamp field:
- Defined: a TS_W-bit free-running cycle counter (wrapping) is sampled on each written beat and placed in the MSBs of rd_data; REC_W = TS_W+DATA_W+EMPTY_W+2.
- Undefined: no counter exists and REC_W = DATA_W+EMPTY_W+2.

Verification
REQ-025 Three 4-beat packets, rd_ready=1 -> 12 records in order with correct sop/eop; pkt_count=3; flags 0.
REQ-026 Single beat with SOP=EOP=1 in IDLE -> one record; pkt_count=1; FSM stays IDLE.
REQ-027 Beat without SOP in IDLE, then SOP during a packet -> err_proto=1; drop_count=1; second packet captured; pkt_count=1.
REQ-028 DEPTH=16, rd_ready=0, one 20-beat packet -> 16 records held; overflow=1; drop_count=1; beats 17-20 absent; pkt_count=0.
REQ-029 Buffer full with rd_ready=1 and a new beat in the same cycle -> beat stored, no overflow.
REQ-030 With CAPTURE_TIMESTAMP_EN, beats at cycles 10 and 13 after reset release -> timestamps differ by 3; reset mid-packet -> no counter change.

Source files
------------

// File: rtl/avalon_st_capture.sv
// Passive Avalon-ST monitor: captures beats into a FWFT FIFO and keeps packet/drop statistics.
// Optional CAPTURE_TIMESTAMP_EN prepends a free-running cycle stamp to each record.
module avalon_st_capture #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32,
`ifdef CAPTURE_TIMESTAMP_EN
  localparam int REC_W  = TS_W + DATA_W + EMPTY_W + 2
`else
  localparam int REC_W  = DATA_W + EMPTY_W + 2
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mon_valid,
  input  logic               mon_startofpacket,
  input  logic               mon_endofpacket,
  input  logic [DATA_W-1:0]  mon_data,
  input  logic [EMPTY_W-1:0] mon_empty,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [REC_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               err_proto,
  output logic               overflow,
  input  logic               clear
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        cnt_q;
  logic [CNT_W-1:0]   pkt_q, drop_q;
  logic               err_q, ovf_q;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [REC_W-1:0]   wr_rec;

  logic full, pop, can_wr, wr_want, wr_en;
  logic err_set, trunc, ovf_set, pkt_inc;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign pop    = rd_valid & rd_ready;
  assign can_wr = ~full | pop;
  assign wr_en  = wr_want & can_wr;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  assign wr_rec = {ts_q, mon_startofpacket, mon_endofpacket, mon_empty, mon_data};
`else
  assign wr_rec = {mon_startofpacket, mon_endofpacket, mon_empty, mon_data};
`endif

  always_comb begin
    state_d = state_q;
    wr_want = 1'b0;
    err_set = 1'b0;
    trunc   = 1'b0;
    ovf_set = 1'b0;
    pkt_inc = 1'b0;
    if (mon_valid) begin
      unique case (state_q)
        IDLE:   if (mon_startofpacket) wr_want = 1'b1; else err_set = 1'b1;
        IN_PKT: begin
          wr_want = 1'b1;
          if (mon_startofpacket) begin err_set = 1'b1; trunc = 1'b1; end
        end
        DROP: begin
          if (mon_startofpacket) begin wr_want = 1'b1; err_set = 1'b1; end
          else if (mon_endofpacket) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // A beat that cannot be stored poisons the rest of its packet.
      if (wr_want) begin
        if (can_wr) begin
          state_d = mon_endofpacket ? IDLE : IN_PKT;
          pkt_inc = mon_endofpacket;
        end else begin
          ovf_set = 1'b1;
          state_d = mon_endofpacket ? IDLE : DROP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (clear) begin
        pkt_q  <= '0;
        drop_q <= '0;
        err_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        pkt_q  <= pkt_q + CNT_W'(pkt_inc);
        drop_q <= drop_q + CNT_W'(trunc) + CNT_W'(ovf_set);
        err_q  <= err_q | err_set;
        ovf_q  <= ovf_q | ovf_set;
      end
    end
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr_q] <= wr_rec;

  assign rd_valid   = (cnt_q != '0);
  assign rd_data    = mem[rd_ptr_q];
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign err_proto  = err_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_avalon_st_capture.sv
// Randomized bench for avalon_st_capture against a packet-level reference model.
module tb_avalon_st_capture;
  localparam int DATA_W = 64, EMPTY_W = 3, DEPTH = 16, CNT_W = 16, TS_W = 32;
`ifdef CAPTURE_TIMESTAMP_EN
  localparam int REC_W = TS_W + DATA_W + EMPTY_W + 2;
`else
  localparam int REC_W = DATA_W + EMPTY_W + 2;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic mon_valid = 0, mon_sop = 0, mon_eop = 0, rd_ready = 0, clear = 0;
  logic [DATA_W-1:0]  mon_data = '0;
  logic [EMPTY_W-1:0] mon_empty = '0;
  logic               rd_valid, err_proto, overflow;
  logic [REC_W-1:0]   rd_data;
  logic [CNT_W-1:0]   pkt_count, drop_count;

  avalon_st_capture #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .reset_n(reset_n), .mon_valid(mon_valid), .mon_startofpacket(mon_sop),
    .mon_endofpacket(mon_eop), .mon_data(mon_data), .mon_empty(mon_empty),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .pkt_count(pkt_count),
    .drop_count(drop_count), .err_proto(err_proto), .overflow(overflow), .clear(clear));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packet-level bookkeeping (are we inside a kept packet, or skipping a lost one).
  logic [REC_W-1:0] q[$];
  bit               in_pkt, skipping;
  logic [CNT_W-1:0] m_pkt, m_drop;
  bit               m_err, m_ovf;
  longint           m_cyc;

  task automatic model_reset();
    q.delete(); in_pkt = 0; skipping = 0;
    m_pkt = '0; m_drop = '0; m_err = 0; m_ovf = 0; m_cyc = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".rd_valid"}, 128'(rd_valid), 128'(q.size() != 0));
    if (q.size() != 0) chk({ctx, ".rd_data"}, 128'(rd_data), 128'(q[0]));
    chk({ctx, ".pkt_count"}, 128'(pkt_count), 128'(m_pkt));
    chk({ctx, ".drop_count"}, 128'(drop_count), 128'(m_drop));
    chk({ctx, ".err_proto"}, 128'(err_proto), 128'(m_err));
    chk({ctx, ".overflow"}, 128'(overflow), 128'(m_ovf));
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance model at posedge.
  task automatic step(input string ctx, input bit v, input bit s, input bit e, input bit rdy, input bit clr);
    logic [REC_W-1:0] rec;
    bit popped, room, want;
    mon_valid = v; mon_sop = s; mon_eop = e; rd_ready = rdy; clear = clr;
    mon_data  = {$urandom, $urandom};
    mon_empty = EMPTY_W'($urandom);
    #1;
    check_outputs(ctx);
    @(posedge clk);
`ifdef CAPTURE_TIMESTAMP_EN
    rec = {TS_W'(m_cyc), s, e, mon_empty, mon_data};
`else
    rec = {s, e, mon_empty, mon_data};
`endif
    popped = rdy && q.size() != 0;
    room   = (q.size() < DEPTH) || popped;
    if (popped) void'(q.pop_front());
    if (v) begin
      want = 0;
      if (s) begin
        want = 1;
        if (in_pkt || skipping) m_err = 1;
        if (in_pkt) m_drop++;
      end else if (in_pkt) want = 1;
      else if (skipping) begin if (e) skipping = 0; end
      else m_err = 1;
      if (want) begin
        if (room) begin
          q.push_back(rec);
          in_pkt = !e; skipping = 0;
          if (e) m_pkt++;
        end else begin
          m_ovf = 1; m_drop++;
          in_pkt = 0; skipping = !e;
        end
      end
    end
    if (clr) begin m_pkt = '0; m_drop = '0; m_err = 0; m_ovf = 0; end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0;
    mon_valid = 0; rd_ready = 0; clear = 0;
    model_reset();
    #1;
    chk("reset.rd_valid", 128'(rd_valid), 128'(0));
    chk("reset.pkt_count", 128'(pkt_count), 128'(0));
    chk("reset.drop_count", 128'(drop_count), 128'(0));
    chk("reset.flags", 128'({err_proto, overflow}), 128'(0));
    @(negedge clk); @(negedge clk);
    reset_n = 1;
  endtask

  task automatic packet(input string ctx, input int len, input bit rdy);
    for (int i = 0; i < len; i++) step(ctx, 1, i == 0, i == len - 1, rdy, 0);
  endtask

  task automatic drain(input string ctx);
    for (int i = 0; i < DEPTH + 2; i++) step(ctx, 0, 0, 0, 1, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    for (int p = 0; p < 3; p++) packet("three_pkts", 4, 1);
    drain("three_pkts_drain");
    chk("three_pkts.pkt_count", 128'(pkt_count), 128'(3));

    step("clr", 0, 0, 0, 1, 1);
    step("single", 1, 1, 1, 1, 0);
    step("single_idle", 1, 0, 0, 1, 0);   // still IDLE: orphan beat flags err_proto
    drain("single_drain");
    chk("single.pkt_count", 128'(pkt_count), 128'(1));

    step("clr", 0, 0, 0, 1, 1);
    step("orphan", 1, 0, 1, 1, 0);
    step("trunc", 1, 1, 0, 1, 0);
    step("trunc", 1, 0, 0, 1, 0);
    packet("trunc_new", 3, 1);
    drain("trunc_drain");
    chk("trunc.drop_count", 128'(drop_count), 128'(1));
    chk("trunc.pkt_count", 128'(pkt_count), 128'(1));

    step("clr", 0, 0, 0, 1, 1);
    packet("ovf20", 20, 0);
    chk("ovf20.overflow", 128'(overflow), 128'(1));
    chk("ovf20.drop_count", 128'(drop_count), 128'(1));
    chk("ovf20.pkt_count", 128'(pkt_count), 128'(0));
    drain("ovf20_drain");

    step("clr", 0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) step("fill", 1, i == 0, 0, 0, 0);
    step("full_pop_wr", 1, 0, 1, 1, 0);
    chk("full_pop_wr.overflow", 128'(overflow), 128'(0));
    chk("full_pop_wr.pkt_count", 128'(pkt_count), 128'(1));
    drain("full_drain");

    step("mid", 1, 1, 0, 1, 0);
    step("mid", 1, 0, 0, 1, 0);
    do_reset();
    step("post_rst", 1, 0, 1, 1, 0);
    packet("post_rst_pkt", 2, 1);
    drain("post_rst_drain");

`ifdef CAPTURE_TIMESTAMP_EN
    begin
      logic [TS_W-1:0] t0;
      do_reset();
      for (int i = 0; i < 10; i++) step("ts_gap", 0, 0, 0, 0, 0);
      step("ts_a", 1, 1, 0, 0, 0);
      step("ts_gap", 0, 0, 0, 0, 0);
      step("ts_gap", 0, 0, 0, 0, 0);
      step("ts_b", 1, 0, 1, 0, 0);
      t0 = rd_data[REC_W-1 -: TS_W];
      chk("ts.first", 128'(t0), 128'(10));
      step("ts_pop", 0, 0, 0, 1, 0);
      chk("ts.delta", 128'(rd_data[REC_W-1 -: TS_W] - t0), 128'(3));
      drain("ts_drain");
    end
`endif

    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 99);
      step("rand", r < 70, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < ((i / 500) % 2 ? 80 : 30), $urandom_range(0, 199) == 0);
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
